// File: rtl/ibex_csr_bank_pkg.sv
// Shared types for the shadowed CSR bank: scrubber state encoding.
package ibex_csr_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ERROR = 2'd2
  } scrub_state_e;

endpackage

// File: rtl/ibex_csr.sv
// Single shadowed CSR: the value plus an optional inverted shadow copy.
// rd_error_o flags any disagreement between the two.
module ibex_csr #(
  parameter int unsigned      Width      = 32,
  parameter bit               ShadowCopy = 1'b1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  output logic [Width-1:0] rd_data_o,
  output logic             rd_error_o
);

  logic [Width-1:0] rdata_q;
  logic [Width-1:0] shadow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= ResetValue;
    end else if (wr_en_i) begin
      rdata_q <= wr_data_i;
    end
  end

  if (ShadowCopy) begin : g_shadow
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        shadow_q <= ~ResetValue;
      end else if (wr_en_i) begin
        shadow_q <= ~wr_data_i;
      end
    end
    assign rd_error_o = (rdata_q != ~shadow_q);
  end else begin : g_no_shadow
    // Kept as a constant so the name exists for every configuration.
    assign shadow_q   = ~ResetValue;
    assign rd_error_o = 1'b0;
  end

  assign rd_data_o = rdata_q;

endmodule

// File: rtl/ibex_csr_bank.sv
// Bank of shadowed CSRs with masked writes, sticky per-register locks and a
// background scrubber that walks the bank looking for shadow mismatches.
module ibex_csr_bank
  import ibex_csr_bank_pkg::*;
#(
  parameter int unsigned      Width      = 32,
  parameter int unsigned      NumRegs    = 4,
  parameter bit               ShadowCopy = 1'b1,
  parameter logic [Width-1:0] ResetValue = '0,
  localparam int unsigned     AW         = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [Width-1:0]   wr_data_i,
  input  logic [Width-1:0]   wr_mask_i,
  input  logic               lock_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [Width-1:0]   rd_data_o,
  output logic               rd_error_o,
  output logic               wr_blocked_o,
  output logic [NumRegs-1:0] locked_o,
  output logic               scrub_err_o,
  output logic [AW-1:0]      scrub_idx_o,
  input  logic               scrub_clr_i
);

  logic [NumRegs*Width-1:0] csr_wdata;
  logic [NumRegs*Width-1:0] csr_rdata;
  logic [NumRegs-1:0]       csr_we;
  logic [NumRegs-1:0]       csr_err;

  logic [NumRegs-1:0] locked_q, locked_d;
  logic               wr_blocked_q, wr_blocked_d;

  scrub_state_e  state_q;
  logic [AW-1:0] ptr_q, ptr_nxt;
  logic          scrub_err_q;
  logic [AW-1:0] scrub_idx_q;
  logic          scrub_mis;

  // Instance array keeps each entry reachable as u_csr[i].
  ibex_csr #(
    .Width      (Width),
    .ShadowCopy (ShadowCopy),
    .ResetValue (ResetValue)
  ) u_csr [NumRegs-1:0] (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .wr_en_i    (csr_we),
    .wr_data_i  (csr_wdata),
    .rd_data_o  (csr_rdata),
    .rd_error_o (csr_err)
  );

  always_comb begin
    csr_we       = '0;
    csr_wdata    = '0;
    locked_d     = locked_q;
    wr_blocked_d = 1'b0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      csr_wdata[i*Width +: Width] = (csr_rdata[i*Width +: Width] & ~wr_mask_i) |
                                    (wr_data_i & wr_mask_i);
      if (wr_en_i && (wr_addr_i == AW'(i))) begin
        if (locked_q[i]) begin
          wr_blocked_d = 1'b1;
        end else begin
          csr_we[i] = 1'b1;
          if (lock_i) locked_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_data_o  = '0;
    rd_error_o = 1'b0;
    scrub_mis  = 1'b0;
    for (int unsigned i = 0; i < NumRegs; i++) begin
      if (rd_addr_i == AW'(i)) begin
        rd_data_o  = csr_rdata[i*Width +: Width];
        rd_error_o = csr_err[i];
      end
      if (ptr_q == AW'(i)) scrub_mis = csr_err[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_q     <= '0;
      wr_blocked_q <= 1'b0;
    end else begin
      locked_q     <= locked_d;
      wr_blocked_q <= wr_blocked_d;
    end
  end

  assign ptr_nxt = (ptr_q == AW'(NumRegs - 1)) ? '0 : ptr_q + 1'b1;

  // Scrubber compares registered state, so a same-cycle write is seen next pass.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      scrub_err_q <= 1'b0;
      scrub_idx_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ShadowCopy) state_q <= CHECK;
        end
        CHECK: begin
          if (scrub_mis) begin
            state_q     <= ERROR;
            scrub_err_q <= 1'b1;
            scrub_idx_q <= ptr_q;
          end else begin
            ptr_q <= ptr_nxt;
          end
        end
        ERROR: begin
          if (scrub_clr_i) begin
            state_q     <= CHECK;
            scrub_err_q <= 1'b0;
            ptr_q       <= ptr_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_blocked_o = wr_blocked_q;
  assign locked_o     = locked_q;
  assign scrub_err_o  = scrub_err_q;
  assign scrub_idx_o  = scrub_idx_q;

endmodule

// File: tb/tb_ibex_csr_bank.sv
// Self-checking bench for ibex_csr_bank: expected register values are queued
// as writes are driven and popped when the result becomes visible.
module tb_ibex_csr_bank;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          wr_en_i = 1'b0;
  logic [AW-1:0] wr_addr_i = '0;
  logic [W-1:0]  wr_data_i = '0;
  logic [W-1:0]  wr_mask_i = '0;
  logic          lock_i = 1'b0;
  logic [AW-1:0] rd_addr_i = '0;
  logic [W-1:0]  rd_data_o;
  logic          rd_error_o;
  logic          wr_blocked_o;
  logic [N-1:0]  locked_o;
  logic          scrub_err_o;
  logic [AW-1:0] scrub_idx_o;
  logic          scrub_clr_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mdl [N];
  logic [N-1:0] mdl_lock;
  logic [W-1:0] exp_q [$];
  logic         exp_blk_q [$];
  logic [W-1:0] fault_val;

  ibex_csr_bank dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .wr_mask_i    (wr_mask_i),
    .lock_i       (lock_i),
    .rd_addr_i    (rd_addr_i),
    .rd_data_o    (rd_data_o),
    .rd_error_o   (rd_error_o),
    .wr_blocked_o (wr_blocked_o),
    .locked_o     (locked_o),
    .scrub_err_o  (scrub_err_o),
    .scrub_idx_o  (scrub_idx_o),
    .scrub_clr_i  (scrub_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    for (int i = 0; i < N; i++) mdl[i] = '0;
    mdl_lock = '0;
  endtask

  // Drives one write for the coming edge and queues its expected outcome.
  task automatic drive_write(input int a, input logic [W-1:0] d, input logic [W-1:0] m,
                             input logic lk);
    wr_en_i   = 1'b1;
    wr_addr_i = AW'(a);
    wr_data_i = d;
    wr_mask_i = m;
    lock_i    = lk;
    if (mdl_lock[a]) begin
      exp_blk_q.push_back(1'b1);
    end else begin
      mdl[a] = (mdl[a] & ~m) | (d & m);
      if (lk) mdl_lock[a] = 1'b1;
      exp_blk_q.push_back(1'b0);
    end
    exp_q.push_back(mdl[a]);
  endtask

  task automatic idle_inputs();
    wr_en_i = 1'b0;
    lock_i  = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if (locked_o !== 4'b0000 || scrub_err_o !== 1'b0 || wr_blocked_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_in_reset locked=%b err=%b blk=%b exp 0000/0/0", locked_o, scrub_err_o,
               wr_blocked_o);
    end
    rst_ni = 1'b1;
    for (int i = 0; i < N; i++) begin
      rd_addr_i = AW'(i);
      #1;
      n_cmp++;
      if (rd_data_o !== 32'h0 || rd_error_o !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_read idx=%0d data=%h err=%b exp 00000000/0", i, rd_data_o, rd_error_o);
      end
    end
    n_cmp++;
    if (locked_o !== 4'b0000 || scrub_idx_o !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_state locked=%b idx=%0d exp 0000/0", locked_o, scrub_idx_o);
    end
  endtask

  task automatic test_masked_write();
    logic [W-1:0] exp;
    logic         eblk;
    @(negedge clk_i);
    drive_write(2, 32'hFFFF_FFFF, 32'h0000_FF00, 1'b0);
    rd_addr_i = 2'd2;
    #1;
    n_cmp++;
    if (rd_data_o !== 32'h0) begin
      n_bad++;
      $display("FAIL mask_same_cycle got=%h exp=00000000", rd_data_o);
    end
    @(negedge clk_i);
    drive_write(2, 32'h0000_0000, 32'h0000_0F00, 1'b0);
    #1;
    exp  = exp_q.pop_front();
    eblk = exp_blk_q.pop_front();
    n_cmp++;
    if (rd_data_o !== exp || wr_blocked_o !== eblk) begin
      n_bad++;
      $display("FAIL mask_write1 got=%h blk=%b exp=%h blk=%b", rd_data_o, wr_blocked_o, exp, eblk);
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    exp  = exp_q.pop_front();
    eblk = exp_blk_q.pop_front();
    n_cmp++;
    if (rd_data_o !== exp || rd_error_o !== 1'b0) begin
      n_bad++;
      $display("FAIL mask_write2 got=%h err=%b exp=%h err=0", rd_data_o, rd_error_o, exp);
    end
  endtask

  task automatic test_lock();
    logic [W-1:0] exp;
    logic         eblk;
    @(negedge clk_i);
    drive_write(1, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b1);
    rd_addr_i = 2'd1;
    @(negedge clk_i);
    drive_write(1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    #1;
    exp  = exp_q.pop_front();
    eblk = exp_blk_q.pop_front();
    n_cmp++;
    if (rd_data_o !== exp || locked_o !== mdl_lock) begin
      n_bad++;
      $display("FAIL lock_set data=%h locked=%b exp=%h locked=%b", rd_data_o, locked_o, exp, mdl_lock);
    end
    @(negedge clk_i);
    idle_inputs();
    #1;
    exp  = exp_q.pop_front();
    eblk = exp_blk_q.pop_front();
    n_cmp++;
    if (rd_data_o !== exp || wr_blocked_o !== eblk) begin
      n_bad++;
      $display("FAIL lock_block data=%h blk=%b exp=%h blk=%b", rd_data_o, wr_blocked_o, exp, eblk);
    end
    @(negedge clk_i);
    n_cmp++;
    if (wr_blocked_o !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_pulse_width blk=%b exp=0", wr_blocked_o);
    end
  endtask

  task automatic test_back_to_back();
    int           ta [5];
    logic [W-1:0] td [5];
    logic [W-1:0] tm [5];
    logic [W-1:0] exp;
    logic         eblk;
    ta = '{0, 1, 3, 0, 3};
    td = '{32'h1111_1111, 32'h0000_0000, 32'hCAFE_F00D, 32'h2222_2222, 32'h0000_0000};
    tm = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_000F};
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk_i);
      if (k == 5) idle_inputs();
      if (k > 0) begin
        rd_addr_i = AW'(ta[k-1]);
        #1;
        exp  = exp_q.pop_front();
        eblk = exp_blk_q.pop_front();
        n_cmp++;
        if (rd_data_o !== exp || wr_blocked_o !== eblk) begin
          n_bad++;
          $display("FAIL b2b_%0d idx=%0d got=%h blk=%b exp=%h blk=%b", k - 1, ta[k-1], rd_data_o,
                   wr_blocked_o, exp, eblk);
        end
      end
      if (k < 5) drive_write(ta[k], td[k], tm[k], 1'b0);
    end
  endtask

  task automatic test_fault();
    bit seen;
    @(negedge clk_i);
    n_cmp++;
    if (scrub_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_pre err=%b exp=0", scrub_err_o);
    end
    fault_val = ~mdl[3] ^ 32'h0000_0001;
    force dut.u_csr[3].shadow_q = fault_val;
    rd_addr_i = 2'd3;
    #1;
    n_cmp++;
    if (rd_error_o !== 1'b1) begin
      n_bad++;
      $display("FAIL fault_rd_err idx=3 got=%b exp=1", rd_error_o);
    end
    rd_addr_i = 2'd2;
    #1;
    n_cmp++;
    if (rd_error_o !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_rd_err idx=2 got=%b exp=0", rd_error_o);
    end
    seen = 1'b0;
    for (int c = 0; c < N + 1 && !seen; c++) begin
      @(negedge clk_i);
      if (scrub_err_o === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || scrub_idx_o !== 2'd3) begin
      n_bad++;
      $display("FAIL fault_scrub seen=%b idx=%0d exp 1/3", seen, scrub_idx_o);
    end
    repeat (5) @(negedge clk_i);
    n_cmp++;
    if (scrub_err_o !== 1'b1) begin
      n_bad++;
      $display("FAIL fault_sticky err=%b exp=1", scrub_err_o);
    end
  endtask

  task automatic test_clear_recheck();
    bit           seen;
    int           low;
    int           highs;
    logic [W-1:0] exp;
    logic         eblk;
    @(negedge clk_i);
    scrub_clr_i = 1'b1;
    @(negedge clk_i);
    scrub_clr_i = 1'b0;
    #1;
    n_cmp++;
    if (scrub_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_drop err=%b exp=0", scrub_err_o);
    end
    seen = 1'b0;
    low  = 1;
    for (int c = 0; c < N + 2 && !seen; c++) begin
      @(negedge clk_i);
      if (scrub_err_o === 1'b1) seen = 1'b1;
      else low++;
    end
    n_cmp++;
    if (!seen || low > N || scrub_idx_o !== 2'd3) begin
      n_bad++;
      $display("FAIL clr_recheck seen=%b low_cycles=%0d idx=%0d exp 1/<=%0d/3", seen, low,
               scrub_idx_o, N);
    end
    release dut.u_csr[3].shadow_q;
    @(negedge clk_i);
    drive_write(3, mdl[3], 32'hFFFF_FFFF, 1'b0);
    @(negedge clk_i);
    idle_inputs();
    rd_addr_i = 2'd3;
    #1;
    exp  = exp_q.pop_front();
    eblk = exp_blk_q.pop_front();
    n_cmp++;
    if (rd_data_o !== exp || rd_error_o !== 1'b0 || wr_blocked_o !== eblk) begin
      n_bad++;
      $display("FAIL repair data=%h err=%b blk=%b exp=%h/0/%b", rd_data_o, rd_error_o, wr_blocked_o,
               exp, eblk);
    end
    scrub_clr_i = 1'b1;
    @(negedge clk_i);
    scrub_clr_i = 1'b0;
    highs = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_i);
      if (scrub_err_o !== 1'b0) highs++;
    end
    n_cmp++;
    if (highs !== 0) begin
      n_bad++;
      $display("FAIL clr_quiet high_cycles=%0d exp=0", highs);
    end
  endtask

  task automatic test_reset_mid_lock();
    logic [W-1:0] exp;
    logic         eblk;
    @(negedge clk_i);
    drive_write(0, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b1);
    rd_addr_i = 2'd0;
    @(negedge clk_i);
    idle_inputs();
    #1;
    exp  = exp_q.pop_front();
    eblk = exp_blk_q.pop_front();
    n_cmp++;
    if (rd_data_o !== exp || locked_o !== mdl_lock) begin
      n_bad++;
      $display("FAIL rml_locked data=%h locked=%b exp=%h locked=%b", rd_data_o, locked_o, exp,
               mdl_lock);
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (locked_o !== 4'b0000 || rd_data_o !== 32'h0 || scrub_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rml_async locked=%b data=%h err=%b exp 0000/00000000/0", locked_o, rd_data_o,
               scrub_err_o);
    end
    #2;
    rst_ni = 1'b1;
    model_reset();
    @(negedge clk_i);
    drive_write(0, 32'h0000_0042, 32'h0000_00FF, 1'b0);
    @(negedge clk_i);
    idle_inputs();
    #1;
    exp  = exp_q.pop_front();
    eblk = exp_blk_q.pop_front();
    n_cmp++;
    if (rd_data_o !== exp || wr_blocked_o !== eblk || locked_o !== 4'b0000) begin
      n_bad++;
      $display("FAIL rml_after data=%h blk=%b locked=%b exp=%h/%b/0000", rd_data_o, wr_blocked_o,
               locked_o, exp, eblk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_masked_write();
    test_lock();
    test_back_to_back();
    test_fault();
    test_clear_recheck();
    test_reset_mid_lock();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
